multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM for the no-pipeline core; drives the ALU's aluCtrl_in and all datapath enables.
//  Sequences fetch/decode/execute per instruction from IR opcode/funct and consumes the ALU's zero_out for beq.
//  Sits between the instruction register and the datapath (PC, memory, register file, ALU muxes).
// PARAMETERS
//  OPCODE_W   6  instruction opcode field width
//  FUNCT_W    6  R-type funct field width
//  ALUCTRL_W  4  width of aluCtrl_out (matches ALU aluCtrl_in)
// PORTS
//  clk_in        in   1          clock, all state updates on rising edge
//  rst_n_in      in   1          synchronous active-low reset
//  opcode_in     in   OPCODE_W   IR[31:26], stable from end of FETCH until next FETCH
//  funct_in      in   FUNCT_W    IR[5:0]
//  zero_in       in   1          ALU zero_out
//  aluCtrl_out   out  ALUCTRL_W  ALU operation: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100
//  aluSrcA_out   out  1          0=PC, 1=regA
//  aluSrcB_out   out  2          00=regB, 01=const 1 word, 10=signext imm, 11=signext imm<<2
//  pcSrc_out     out  2          00=ALU result, 01=ALUOut reg, 10=jump target
//  pcWriteEn_out out  1          pcWrite | (branch & zero_in)
//  iorD_out, memRead_out, memWrite_out, irWrite_out, regDst_out, memToReg_out, regWrite_out  out 1 each
//  illegal_out   out  1          1-cycle pulse on unsupported opcode/funct
//  state_out     out  4          current state encoding (debug)
// BEHAVIOUR
//  Moore outputs decoded from state reg; pcWriteEn_out additionally depends on zero_in in BRANCH.
//  Reset: while rst_n_in=0, pcWriteEn/memRead/memWrite/irWrite/regWrite/illegal forced 0, others 0;
//   state<=FETCH on edge. Mid-instruction reset aborts without any write. First FETCH = first cycle rst_n_in=1.
//  Unlisted outputs are 0 in each state. aluOp: 00->add, 01->sub, 10->funct decode.
//  FETCH(0):   memRead irWrite pcWrite, srcA=0 srcB=01 aluOp=00 pcSrc=00 -> DECODE
//  DECODE(1):  srcA=0 srcB=11 aluOp=00; 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH,
//              000010->JUMP, 001000->ADDIEXEC (macro); else illegal_out=1 -> FETCH
//  MEMADR(2):  srcA=1 srcB=10 aluOp=00 -> MEMREAD if lw, MEMWRITE if sw
//  MEMREAD(3): iorD memRead -> MEMWB;  MEMWB(4): memToReg regWrite regDst=0 -> FETCH
//  MEMWRITE(5): iorD memWrite -> FETCH
//  EXECUTE(6): srcA=1 srcB=00 aluOp=10 -> ALUWB; unsupported funct: illegal_out=1 -> FETCH (no write)
//  ALUWB(7):   regDst=1 regWrite -> FETCH
//  BRANCH(8):  srcA=1 srcB=00 aluOp=01 pcSrc=01 branch -> FETCH
//  ADDIEXEC(9): srcA=1 srcB=10 aluOp=00 -> ADDIWB;  ADDIWB(10): regDst=0 regWrite -> FETCH
//  JUMP(11):   pcSrc=10 pcWrite -> FETCH.  Codes 12-15 unreachable; if entered -> FETCH, no enables.
//  funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor; other -> add + illegal.
//  Latency (cycles incl. FETCH): lw 5, sw 4, R 4, addi 4, beq 3, j 3.
// CONFIGURATION
//  `ADDI_SUPPORT_EN defined: opcode 001000 -> ADDIEXEC/ADDIWB.
//  Not defined: states 9/10 not built; 001000 treated as illegal in DECODE.
// STRUCTURE
//  mips_pkg: operation_t enum (encodings above, shared with ALU bench), opcode/funct localparams,
//   aluOp encodings, state_t enum.
//  Sub-module alu_control: combinational aluOp+funct -> aluCtrl_out, illegal funct flag.
// TESTING
//  Reset: rst_n_in=0 2 cycles -> all enables 0; release -> state 0, memRead=irWrite=pcWriteEn=1, aluCtrl=0010.
//  R-type 000000/100010: states 0,1,6,7; aluCtrl=0110 in EXECUTE; regWrite=regDst=1 in ALUWB;
//   repeat funct 101010->0111, 100111->1100, 100100->0000, 100101->0001.
//  lw 100011: states 0,1,2,3,4; memToReg=regWrite=1 in MEMWB. sw 101011: 0,1,2,5; memWrite=1, regWrite never.
//  beq 000100 zero_in=1: BRANCH aluCtrl=0110 pcSrc=01 pcWriteEn=1; zero_in=0 -> pcWriteEn=0.
//  j 000010: states 0,1,11, pcSrc=10 pcWriteEn=1; opcode 111111 -> illegal_out pulse in DECODE, next FETCH;
//   funct 000000 -> illegal in EXECUTE, no regWrite; rst_n_in=0 during MEMREAD -> no MEMWB, state 0.
//  addi 001000: with macro states 0,1,9,10, regWrite in ADDIWB; without macro illegal_out in DECODE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: ALU operation codes,
// opcode/funct values, aluOp encodings, controller states and the decode helper.
// Optional ADDI support is enabled by defining ADDI_SUPPORT_EN.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100
    } operation_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Datapath strobes and mux selects; everything except the ALU operation.
    typedef struct packed {
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // State that follows DECODE for a given opcode; S_FETCH marks an unsupported opcode.
    function automatic state_t decode_target(input logic [5:0] opcode);
        state_t target;
        case (opcode)
            OPC_LW, OPC_SW: target = S_MEMADR;
            OPC_RTYPE:      target = S_EXECUTE;
            OPC_BEQ:        target = S_BRANCH;
            OPC_J:          target = S_JUMP;
`ifdef ADDI_SUPPORT_EN
            OPC_ADDI:       target = S_ADDIEXEC;
`endif
            default:        target = S_FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_control.sv
// ALU control decoder: maps aluOp plus R-type funct to the ALU operation code and
// flags funct values the core does not implement (those fall back to add).
module alu_control
    import mips_pkg::*;
#(
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           i_alu_op,
    input  logic [FUNCT_W-1:0]   i_funct,
    output logic [ALUCTRL_W-1:0] o_alu_ctrl,
    output logic                 o_illegal_funct
);

    operation_t w_op;
    logic       w_illegal;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: w_op = OP_ADD;
            ALUOP_SUB: w_op = OP_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  w_op = OP_ADD;
                    FN_SUB:  w_op = OP_SUB;
                    FN_AND:  w_op = OP_AND;
                    FN_OR:   w_op = OP_OR;
                    FN_SLT:  w_op = OP_SLT;
                    FN_NOR:  w_op = OP_NOR;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_op = OP_ADD;
        endcase
    end

    assign o_alu_ctrl      = ALUCTRL_W'(w_op);
    assign o_illegal_funct = w_illegal;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute from the IR fields and
// drives the ALU operation plus all datapath enables. ADDI_SUPPORT_EN adds addi states.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [OPCODE_W-1:0]  opcode_in,
    input  logic [FUNCT_W-1:0]   funct_in,
    input  logic                 zero_in,
    output logic [ALUCTRL_W-1:0] aluCtrl_out,
    output logic                 aluSrcA_out,
    output logic [1:0]           aluSrcB_out,
    output logic [1:0]           pcSrc_out,
    output logic                 pcWriteEn_out,
    output logic                 iorD_out,
    output logic                 memRead_out,
    output logic                 memWrite_out,
    output logic                 irWrite_out,
    output logic                 regDst_out,
    output logic                 memToReg_out,
    output logic                 regWrite_out,
    output logic                 illegal_out,
    output logic [3:0]           state_out
);

    state_t                r_state;
    state_t                w_next_state;
    state_t                w_decode_target;
    alu_op_t               w_alu_op;
    ctrl_t                 w_ctrl;
    ctrl_t                 w_ctrl_out;
    logic [ALUCTRL_W-1:0]  w_alu_ctrl;
    logic                  w_illegal_funct;
    logic                  w_illegal;

    assign w_decode_target = decode_target(opcode_in);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE:   w_next_state = w_decode_target;
            S_MEMADR:   w_next_state = (opcode_in == OPC_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTE:  w_next_state = w_illegal_funct ? S_FETCH : S_ALUWB;
`ifdef ADDI_SUPPORT_EN
            S_ADDIEXEC: w_next_state = S_ADDIWB;
`endif
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Kept apart from the strobe decode so the funct check never loops back into it.
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (r_state)
            S_EXECUTE: w_alu_op = ALUOP_FUNCT;
            S_BRANCH:  w_alu_op = ALUOP_SUB;
            default:   w_alu_op = ALUOP_ADD;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ir_write = 1'b1;
                w_ctrl.pc_write = 1'b1;
                w_ctrl.src_b    = 2'b01;
            end
            S_DECODE:   w_ctrl.src_b = 2'b11;
            S_MEMADR: begin
                w_ctrl.src_a = 1'b1;
                w_ctrl.src_b = 2'b10;
            end
            S_MEMREAD: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE:  w_ctrl.src_a = 1'b1;
            S_ALUWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.src_a  = 1'b1;
                w_ctrl.pc_src = 2'b01;
                w_ctrl.branch = 1'b1;
            end
`ifdef ADDI_SUPPORT_EN
            S_ADDIEXEC: begin
                w_ctrl.src_a = 1'b1;
                w_ctrl.src_b = 2'b10;
            end
            S_ADDIWB:   w_ctrl.reg_write = 1'b1;
`endif
            S_JUMP: begin
                w_ctrl.pc_src   = 2'b10;
                w_ctrl.pc_write = 1'b1;
            end
            default:    w_ctrl = '0;
        endcase
    end

    alu_control #(
        .FUNCT_W   (FUNCT_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_control (
        .i_alu_op        (w_alu_op),
        .i_funct         (funct_in),
        .o_alu_ctrl      (w_alu_ctrl),
        .o_illegal_funct (w_illegal_funct)
    );

    assign w_illegal = ((r_state == S_DECODE)  && (w_decode_target == S_FETCH)) ||
                       ((r_state == S_EXECUTE) && w_illegal_funct);

    // Reset is sampled synchronously, but outputs are masked combinationally so an
    // aborted instruction never issues a write in the cycle reset is asserted.
    assign w_ctrl_out    = rst_n_in ? w_ctrl : '0;
    assign aluCtrl_out   = rst_n_in ? w_alu_ctrl : '0;
    assign state_out     = rst_n_in ? r_state : 4'd0;
    assign illegal_out   = rst_n_in & w_illegal;
    assign pcWriteEn_out = w_ctrl_out.pc_write | (w_ctrl_out.branch & zero_in);

    assign aluSrcA_out   = w_ctrl_out.src_a;
    assign aluSrcB_out   = w_ctrl_out.src_b;
    assign pcSrc_out     = w_ctrl_out.pc_src;
    assign iorD_out      = w_ctrl_out.iord;
    assign memRead_out   = w_ctrl_out.mem_read;
    assign memWrite_out  = w_ctrl_out.mem_write;
    assign irWrite_out   = w_ctrl_out.ir_write;
    assign regDst_out    = w_ctrl_out.reg_dst;
    assign memToReg_out  = w_ctrl_out.mem_to_reg;
    assign regWrite_out  = w_ctrl_out.reg_write;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions compared
// cycle by cycle against a per-instruction phase model. Honors ADDI_SUPPORT_EN.
module tb_multicycle_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [5:0] opcode_in;
    logic [5:0] funct_in;
    logic       zero_in;
    logic [3:0] aluCtrl_out;
    logic       aluSrcA_out;
    logic [1:0] aluSrcB_out;
    logic [1:0] pcSrc_out;
    logic       pcWriteEn_out, iorD_out, memRead_out, memWrite_out, irWrite_out;
    logic       regDst_out, memToReg_out, regWrite_out, illegal_out;
    logic [3:0] state_out;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       m2r;
        logic       reg_wr;
        logic       illegal;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_ctrl dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .opcode_in     (opcode_in),
        .funct_in      (funct_in),
        .zero_in       (zero_in),
        .aluCtrl_out   (aluCtrl_out),
        .aluSrcA_out   (aluSrcA_out),
        .aluSrcB_out   (aluSrcB_out),
        .pcSrc_out     (pcSrc_out),
        .pcWriteEn_out (pcWriteEn_out),
        .iorD_out      (iorD_out),
        .memRead_out   (memRead_out),
        .memWrite_out  (memWrite_out),
        .irWrite_out   (irWrite_out),
        .regDst_out    (regDst_out),
        .memToReg_out  (memToReg_out),
        .regWrite_out  (regWrite_out),
        .illegal_out   (illegal_out),
        .state_out     (state_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic obs_t observe();
        return {state_out, aluCtrl_out, aluSrcA_out, aluSrcB_out, pcSrc_out, pcWriteEn_out,
                iorD_out, memRead_out, memWrite_out, irWrite_out, regDst_out, memToReg_out,
                regWrite_out, illegal_out};
    endfunction

    // A quiet cycle in the given state: no enables, ALU doing add.
    function automatic obs_t phase(input int st);
        obs_t c = '0;
        c.state = 4'(st);
        c.alu   = 4'b0010;
        return c;
    endfunction

    function automatic logic [3:0] funct_op(input logic [5:0] fn, output logic known);
        known = 1'b1;
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default: begin
                known = 1'b0;
                return 4'b0010;
            end
        endcase
    endfunction

    // Builds the expected per-cycle trace of one whole instruction, FETCH first.
    function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        obs_t c;
        logic known;
        logic addi_ok;
`ifdef ADDI_SUPPORT_EN
        addi_ok = 1'b1;
`else
        addi_ok = 1'b0;
`endif
        exp_q.delete();
        c = phase(0); c.src_b = 2'b01; c.pc_we = 1; c.mem_rd = 1; c.ir_wr = 1;
        exp_q.push_back(c);
        c = phase(1); c.src_b = 2'b11;
        if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010}) &&
            !(op == 6'b001000 && addi_ok)) begin
            c.illegal = 1;
            exp_q.push_back(c);
            return;
        end
        exp_q.push_back(c);
        case (op)
            6'b100011, 6'b101011: begin
                c = phase(2); c.src_a = 1; c.src_b = 2'b10; exp_q.push_back(c);
                if (op == 6'b100011) begin
                    c = phase(3); c.iord = 1; c.mem_rd = 1; exp_q.push_back(c);
                    c = phase(4); c.m2r = 1; c.reg_wr = 1; exp_q.push_back(c);
                end else begin
                    c = phase(5); c.iord = 1; c.mem_wr = 1; exp_q.push_back(c);
                end
            end
            6'b000000: begin
                c = phase(6); c.src_a = 1; c.alu = funct_op(fn, known); c.illegal = !known;
                exp_q.push_back(c);
                if (known) begin
                    c = phase(7); c.reg_dst = 1; c.reg_wr = 1; exp_q.push_back(c);
                end
            end
            6'b000100: begin
                c = phase(8); c.src_a = 1; c.alu = 4'b0110; c.pc_src = 2'b01; c.pc_we = z;
                exp_q.push_back(c);
            end
            6'b000010: begin
                c = phase(11); c.pc_src = 2'b10; c.pc_we = 1; exp_q.push_back(c);
            end
            default: begin
                c = phase(9); c.src_a = 1; c.src_b = 2'b10; exp_q.push_back(c);
                c = phase(10); c.reg_wr = 1; exp_q.push_back(c);
            end
        endcase
    endfunction

    task automatic compare(input string name, input int cyc, input obs_t exp);
        obs_t got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                     name, cyc, got.state, got, exp.state, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT in FETCH; leaves at the next FETCH.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z);
        model_instr(op, fn, z);
        opcode_in = op;
        funct_in  = fn;
        zero_in   = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk_in);
            compare(name, i, exp_q[i]);
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            opcode_in = 6'($urandom);
            funct_in  = 6'($urandom);
            zero_in   = 1'($urandom);
            @(negedge clk_in);
            compare("reset_hold", i, '0);
            @(posedge clk_in); #1;
        end
        rst_n_in = 1'b1;
        run_instr("first_after_reset", 6'b000000, 6'b100000, 1'b0);
    endtask

    task automatic test_rtype();
        logic [5:0] fns[5] = '{6'b100010, 6'b101010, 6'b100111, 6'b100100, 6'b100101};
        foreach (fns[i]) run_instr("rtype", 6'b000000, fns[i], 1'($urandom));
        run_instr("rtype_bad_funct", 6'b000000, 6'b000000, 1'b0);
    endtask

    task automatic test_mem();
        run_instr("lw", 6'b100011, 6'($urandom), 1'($urandom));
        run_instr("sw", 6'b101011, 6'($urandom), 1'($urandom));
    endtask

    task automatic test_branch_jump();
        run_instr("beq_taken", 6'b000100, 6'($urandom), 1'b1);
        run_instr("beq_not_taken", 6'b000100, 6'($urandom), 1'b0);
        run_instr("jump", 6'b000010, 6'($urandom), 1'($urandom));
        run_instr("illegal_opcode", 6'b111111, 6'($urandom), 1'b0);
        run_instr("addi", 6'b001000, 6'($urandom), 1'($urandom));
    endtask

    task automatic test_mid_reset();
        model_instr(6'b100011, 6'b100000, 1'b0);
        opcode_in = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            compare("lw_pre_abort", i, exp_q[i]);
            @(posedge clk_in); #1;
        end
        rst_n_in = 1'b0;
        @(negedge clk_in);
        compare("lw_abort_in_memread", 3, '0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        run_instr("after_abort", 6'b101011, 6'b100000, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                               6'b001000, 6'b000000};
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                               6'b100111};
        logic [5:0] op, fn;
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr("random", op, fn, 1'($urandom));
        end
    endtask

    initial begin
        rst_n_in  = 1'b0;
        opcode_in = '0;
        funct_in  = '0;
        zero_in   = 1'b0;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
